// File: rtl/demux_stream_1n.sv
// demux_stream_1n: 1-to-N stream demultiplexer with a one-entry register per
// output channel, an all-or-nothing broadcast mode and a saturating counter
// of words dropped because their channel index does not exist.
module demux_stream_1n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   i,
    input  logic [SEL_W-1:0]   sel,
    input  logic               bcast,
    input  logic               i_valid,
    output logic               i_ready,
    output logic [N*WIDTH-1:0] y,
    output logic [N-1:0]       y_valid,
    input  logic [N-1:0]       y_ready,
    output logic [7:0]         drop_cnt
);

    logic [N-1:0] sel_hit;  // one-hot decode of sel; all zero when sel >= N
    logic [N-1:0] free;     // channel register empty or draining this cycle
    logic [N-1:0] load;     // channel register captures i on this edge
    logic         sel_ok;
    logic         xfer;
    logic         drop;

    // Decode the destination, decide acceptance and fan the transfer out.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        sel_hit = '0;
        load    = '0;
        i_ready = 1'b1;
        for (int c = 0; c < N; c++) begin
            sel_hit[c] = (sel == SEL_W'(c));
        end
        sel_ok = |sel_hit;
        free   = ~y_valid | y_ready;

        // Broadcast has priority over sel; an out-of-range sel is always
        // accepted so the word can be dropped and counted.
        if (bcast) begin
            i_ready = &free;
        end else if (sel_ok) begin
            i_ready = |(free & sel_hit);
        end

        xfer = i_valid & i_ready;
        if (xfer) begin
            load = bcast ? {N{1'b1}} : sel_hit;
        end
        drop = xfer & ~bcast & ~sel_ok;
    end

    // Per-channel holding registers: load wins over drain so a channel that
    // empties and refills on the same edge stays valid with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset too because they drive the output bus directly and must read zero out of reset.
            y_valid <= '0;
            y       <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
                if (load[c]) begin
                    y_valid[c]              <= 1'b1;
                    y[c*WIDTH +: WIDTH]     <= i;
                end else if (y_ready[c]) begin
                    y_valid[c]              <= 1'b0;
                end
            end
        end
    end

    // Count words accepted for a non-existent channel, sticking at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_demux_stream_1n.sv
// Testbench for demux_stream_1n (N=4, WIDTH=8, SEL_W=3): directed vector
// table, hand-written multi-cycle sequences, and a randomized run against a
// per-channel queue reference model.
module tb_demux_stream_1n;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic [2:0]  sel;
    logic        bcast;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] y;
    logic [3:0]  y_valid;
    logic [3:0]  y_ready;
    logic [7:0]  drop_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;

    demux_stream_1n #(.WIDTH(8), .N(4), .SEL_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i        (din),
        .sel      (sel),
        .bcast    (bcast),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic        bcast;
        logic        iv;
        logic [7:0]  din;
        logic [3:0]  yr;
        logic        exp_ir;
        logic [3:0]  exp_yv;
        logic [31:0] exp_y;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] s, input logic b, input logic v,
                                input logic [7:0] d, input logic [3:0] r,
                                input logic eir, input logic [3:0] eyv,
                                input logic [31:0] ey, input logic [7:0] edrop);
        vec_t t;
        t.sel = s; t.bcast = b; t.iv = v; t.din = d; t.yr = r;
        t.exp_ir = eir; t.exp_yv = eyv; t.exp_y = ey; t.exp_drop = edrop;
        return t;
    endfunction

    initial begin
        logic [7:0] mq [4][$];
        logic [3:0] free_m;
        logic [3:0] exp_yv;
        logic [31:0] exp_y;
        logic [31:0] act_y;
        logic       exp_ir;
        logic [7:0] drop_m;
        int         bad;

        //           sel   bc  iv  din    yr       ir  yv       y             drop
        vecs[0]  = mk(3'd2, 0, 1, 8'hA5, 4'b0000, 1, 4'b0100, 32'h00A50000, 8'd0);
        vecs[1]  = mk(3'd1, 0, 1, 8'h11, 4'b0000, 1, 4'b0110, 32'h00A51100, 8'd0);
        vecs[2]  = mk(3'd1, 0, 1, 8'h22, 4'b0000, 0, 4'b0110, 32'h00A51100, 8'd0);
        vecs[3]  = mk(3'd1, 0, 1, 8'h22, 4'b0010, 1, 4'b0110, 32'h00A52200, 8'd0);
        vecs[4]  = mk(3'd0, 0, 0, 8'hFF, 4'b1111, 1, 4'b0000, 32'h00A52200, 8'd0);
        vecs[5]  = mk(3'd0, 1, 1, 8'h3C, 4'b1111, 1, 4'b1111, 32'h3C3C3C3C, 8'd0);
        vecs[6]  = mk(3'd0, 1, 1, 8'h55, 4'b0000, 0, 4'b1111, 32'h3C3C3C3C, 8'd0);
        vecs[7]  = mk(3'd0, 1, 1, 8'h55, 4'b0111, 0, 4'b1000, 32'h3C3C3C3C, 8'd0);
        vecs[8]  = mk(3'd0, 1, 1, 8'h66, 4'b1111, 1, 4'b1111, 32'h66666666, 8'd0);
        vecs[9]  = mk(3'd5, 0, 1, 8'h77, 4'b0000, 1, 4'b1111, 32'h66666666, 8'd1);
        vecs[10] = mk(3'd4, 0, 1, 8'h78, 4'b0000, 1, 4'b1111, 32'h66666666, 8'd2);
        vecs[11] = mk(3'd7, 0, 0, 8'h79, 4'b0000, 1, 4'b1111, 32'h66666666, 8'd2);
        vecs[12] = mk(3'd3, 0, 1, 8'h99, 4'b0000, 0, 4'b1111, 32'h66666666, 8'd2);
        vecs[13] = mk(3'd3, 0, 0, 8'h99, 4'b1000, 1, 4'b0111, 32'h66666666, 8'd2);
        vecs[14] = mk(3'd6, 1, 1, 8'hAB, 4'b0000, 0, 4'b0111, 32'h66666666, 8'd2);

        // Reset state
        rst_n = 1'b0; din = '0; sel = '0; bcast = 1'b0; i_valid = 1'b0; y_ready = '0;
        #1;
        check("rst_y_valid", 64'(y_valid), 64'(4'b0000));
        check("rst_y", 64'(y), 64'(32'h0));
        check("rst_drop", 64'(drop_cnt), 64'(8'd0));
        check("rst_i_ready", 64'(i_ready), 64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            sel = vecs[k].sel; bcast = vecs[k].bcast; i_valid = vecs[k].iv;
            din = vecs[k].din; y_ready = vecs[k].yr;
            #1;
            check($sformatf("vec%0d_i_ready", k), 64'(i_ready), 64'(vecs[k].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_y_valid", k), 64'(y_valid), 64'(vecs[k].exp_yv));
            check($sformatf("vec%0d_y", k), 64'(y), 64'(vecs[k].exp_y));
            check($sformatf("vec%0d_drop", k), 64'(drop_cnt), 64'(vecs[k].exp_drop));
        end

        // Invalid sel for 300 cycles: always ready, nothing loaded, counter saturates
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            sel = 3'd5; bcast = 1'b0; i_valid = 1'b1; din = 8'(k); y_ready = 4'b0000;
            #1;
            if (i_ready !== 1'b1) bad++;
        end
        @(posedge clk);
        #1;
        check("sat_ready_low_cycles", 64'(bad), 64'd0);
        check("sat_drop", 64'(drop_cnt), 64'(8'd255));
        check("sat_y_valid", 64'(y_valid), 64'(4'b0111));
        check("sat_y", 64'(y), 64'(32'h66666666));

        // Drain everything, then stream 0x00..0x0F to channel 0 back to back
        @(negedge clk);
        i_valid = 1'b0; y_ready = 4'b1111;
        @(posedge clk);
        #1;
        check("drain_y_valid", 64'(y_valid), 64'(4'b0000));
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            sel = 3'd0; bcast = 1'b0; i_valid = 1'b1; din = 8'(k); y_ready = 4'b0001;
            #1;
            check($sformatf("stream%0d_i_ready", k), 64'(i_ready), 64'(1'b1));
            @(posedge clk);
            #1;
            check($sformatf("stream%0d_word", k), 64'({y_valid, y[7:0]}), 64'({4'b0001, 8'(k)}));
        end

        // Reset asserted mid-stream, between edges
        @(negedge clk);
        din = 8'h10;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_y_valid", 64'(y_valid), 64'(4'b0000));
        check("async_rst_y", 64'(y), 64'(32'h0));
        check("async_rst_drop", 64'(drop_cnt), 64'(8'd0));
        check("async_rst_i_ready", 64'(i_ready), 64'(1'b1));
        bcast = 1'b1;
        #1;
        check("async_rst_bcast_ready", 64'(i_ready), 64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1; i_valid = 1'b0; bcast = 1'b0; y_ready = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", 64'({y_valid, y}), 64'({4'b0000, 32'h0}));

        // Randomized traffic against a queue reference model
        drop_m = 8'd0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) != 0) sel = 3'($urandom_range(0, 3));
            else                           sel = 3'($urandom_range(4, 7));
            bcast   = ($urandom_range(0, 7) == 0);
            i_valid = ($urandom_range(0, 3) != 0);
            din     = 8'($urandom);
            y_ready = 4'($urandom);
            #1;
            exp_y = '0; act_y = '0;
            for (int c = 0; c < 4; c++) begin
                exp_yv[c] = (mq[c].size() != 0);
                free_m[c] = !exp_yv[c] || y_ready[c];
                if (exp_yv[c]) exp_y[c*8 +: 8] = mq[c][0];
                if (y_valid[c]) act_y[c*8 +: 8] = y[c*8 +: 8];
            end
            if (bcast)          exp_ir = &free_m;
            else if (sel < 3'd4) exp_ir = free_m[sel[1:0]];
            else                exp_ir = 1'b1;
            check($sformatf("rand%0d", n),
                  64'({i_ready, y_valid, act_y, drop_cnt}),
                  64'({exp_ir, exp_yv, exp_y, drop_m}));
            for (int c = 0; c < 4; c++) begin
                if (mq[c].size() != 0 && y_ready[c]) void'(mq[c].pop_front());
            end
            if (i_valid && exp_ir) begin
                if (bcast) begin
                    for (int c = 0; c < 4; c++) mq[c].push_back(din);
                end else if (sel < 3'd4) begin
                    mq[sel[1:0]].push_back(din);
                end else if (drop_m != 8'hFF) begin
                    drop_m = drop_m + 8'd1;
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/demux_stream_1n.md
DEMUX_STREAM_1N -- requirements
Module: demux_stream_1n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width per channel in bits.
REQ-002 The block SHALL have parameter N, default 4, meaning the number of output channels (2..16).
REQ-003 The block SHALL have parameter SEL_W, default 3, meaning the select width; 2**SEL_W >= N.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port i, input, WIDTH bits, the input data word.
REQ-007 The block SHALL have port sel, input, SEL_W bits, the destination channel index.
REQ-008 The block SHALL have port bcast, input, 1 bit; when 1, the word goes to all N channels and sel is ignored.
REQ-009 The block SHALL have port i_valid, input, 1 bit, meaning the input word is offered.
REQ-010 The block SHALL have port i_ready, output, 1 bit, meaning the block accepts the word this cycle.
REQ-011 The block SHALL have port y, output, N*WIDTH bits, the packed channel data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-012 The block SHALL have port y_valid, output, N bits, the per-channel data-valid flags.
REQ-013 The block SHALL have port y_ready, input, N bits, the per-channel consumer-ready flags.
REQ-014 The block SHALL have port drop_cnt, output, 8 bits, a saturating count of words dropped for an invalid sel.

Function
REQ-015 Each channel SHALL hold a one-entry register: data y[c] and full flag y_valid[c].
REQ-016 free[c] SHALL be defined as !y_valid[c] | y_ready[c], so the register is free if empty or draining this cycle.
REQ-017 i_ready SHALL be combinational, with priority bcast first: bcast=1 -> AND of free[0..N-1]; sel<N -> free[sel]; sel>=N -> 1.
REQ-018 A transfer SHALL occur on a rising edge where i_valid & i_ready = 1; no other input condition accepts data.
REQ-019 On a transfer with bcast=0 and sel<N, y[sel] SHALL load i and y_valid[sel] SHALL be set; the data is visible the next cycle (latency 1).
REQ-020 On a transfer with bcast=1, all N channels SHALL load i and set y_valid in the same edge (all-or-nothing; no partial broadcast).
REQ-021 On a transfer with bcast=0 and sel>=N, no channel SHALL change and drop_cnt SHALL increment, saturating at 255.
REQ-022 A channel handshake SHALL occur when y_valid[c] & y_ready[c]; absent a simultaneous load, y_valid[c] SHALL clear.
REQ-023 When channel c drains and loads on the same edge, y_valid[c] SHALL stay 1 and y[c] SHALL take the new word, with no bubble.
REQ-024 While y_valid[c]=1 and y_ready[c]=0, y[c] SHALL hold stable.
REQ-025 Channel data SHALL not change on any edge without a load.
REQ-026 i_ready SHALL not depend on i_valid.
REQ-027 The block SHALL never lose or duplicate a word; back-to-back transfers to one channel with y_ready held at 1 SHALL sustain 1 word per cycle.

Reset
REQ-028 When rst_n=0, asynchronously: all y_valid=0, all y=0, drop_cnt=0.
REQ-029 Reset asserted mid-transfer SHALL discard all held words; there SHALL be no output activity until the first transfer after reset is released.
REQ-030 i_ready during reset SHALL follow REQ-017 with all channels empty.

Verification (N=4, WIDTH=8, SEL_W=3)
REQ-031 Reset -> y_valid=4'b0000, y=0, drop_cnt=0; then sel=2, i=8'hA5, i_valid=1 for one cycle -> next cycle y_valid=4'b0100, y[2]=8'hA5.
REQ-032 Fill ch1 with 8'h11, hold y_ready[1]=0, offer sel=1, i=8'h22 -> i_ready=0, y[1] stays 8'h11; raise y_ready[1] -> on the same edge ch1 drains 8'h11 and loads 8'h22, with y_valid[1] held at 1.
REQ-033 bcast=1, i=8'h3C, y_ready=4'b1111, all channels empty -> next cycle y_valid=4'b1111 and every y[c]=8'h3C; repeat with ch3 full and y_ready[3]=0 -> i_ready=0 and no channel changes.
REQ-034 sel=5, i_valid=1 for 300 cycles -> i_ready=1 throughout, no y_valid set, drop_cnt=255 (saturated).
REQ-035 Stream 8'h00..8'h0F to sel=0 with y_ready[0]=1 -> one word accepted per cycle, in order, with no gaps; then rst_n=0 mid-stream -> y_valid=0 immediately (asynchronously).
REQ-036 Random sel/bcast/i_valid/y_ready for 10k cycles checked against a reference queue model -> zero mismatches, no lost words, no duplicated words.
